// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a byte FIFO.
// Ports:
//   clk, rst                 - clock and async active-high reset
//   tx_data/tx_valid/tx_ready - byte push handshake into the FIFO
//   host_rts                 - host flow control, sampled only in IDLE
//   uart_tx                  - registered serial line, idle high
//   busy, fifo_count         - activity and queue depth status
//   overflow                 - sticky, push attempted while full
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16,
    parameter int FLOW_CTRL  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic                          host_rts,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;

    localparam logic [BW-1:0] BAUD_MAX = BW'(DIV - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic          NO_FLOW  = (FLOW_CTRL == 0);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [1:0]    state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          push;
    logic          pop;
    logic          bit_end;

    assign tx_ready = (fifo_count != FULL_CNT);
    assign busy     = (state != IDLE) || (fifo_count != '0);
    assign push     = tx_valid && tx_ready;
    assign pop      = (state == IDLE) && (fifo_count != '0)
                      && (host_rts || NO_FLOW);
    assign bit_end  = (baud_cnt == BAUD_MAX);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 1'b1;
            end
            if (tx_valid && !tx_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            uart_tx   <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    uart_tx <= 1'b1;
                    if (pop) begin
                        shift_reg <= mem[rd_ptr];
                        baud_cnt  <= '0;
                        uart_tx   <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        uart_tx  <= shift_reg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= STOP;
                        end else begin
                            // shift so the next bit is always at [0]
                            bit_idx   <= bit_idx + 1'b1;
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            uart_tx   <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo.
// Frame-position reference model plus an independent line decoder.
module tb_uart_tx_fifo;

    localparam int DIV   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       host_rts = 1'b0;
    logic       uart_tx;
    logic       busy;
    logic [2:0] fifo_count;
    logic       overflow;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLK_FREQ  (16),
        .BAUD      (1),
        .FIFO_DEPTH(DEPTH),
        .FLOW_CTRL (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .host_rts  (host_rts),
        .uart_tx   (uart_tx),
        .busy      (busy),
        .fifo_count(fifo_count),
        .overflow  (overflow)
    );

    int n_cmp = 0;
    int n_err = 0;

    // reference model: queue of bytes plus position inside the frame
    logic [7:0] q[$];
    logic [7:0] sent[$];
    logic [7:0] cur = 8'h00;
    int         fpos = -1;
    bit         m_ovf = 1'b0;
    int         cyc = 0;

    // line decoder
    bit         d_act = 1'b0;
    int         d_cnt = 0;
    logic [7:0] d_byte = 8'h00;
    int         n_frames = 0;
    int         last_start = 0;
    int         prev_start = 0;

    typedef struct {
        bit         v;
        logic [7:0] d;
        bit         r;
        int         e_cnt;
        int         e_rdy;
        int         e_tx;
        int         e_ovf;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic int exp_tx();
        int b;
        if (fpos < 0) return 1;
        b = fpos / DIV;
        if (b == 0) return 0;
        if (b == 9) return 1;
        return int'(cur[b-1]);
    endfunction

    task automatic model_update(input bit v, input logic [7:0] d,
                                input bit r);
        bit full;
        full = (q.size() == DEPTH);
        if (fpos >= 0) begin
            fpos++;
            if (fpos == 10 * DIV) fpos = -1;
        end else if (q.size() != 0 && r) begin
            cur  = q.pop_front();
            fpos = 0;
            sent.push_back(cur);
        end
        if (v) begin
            if (!full) q.push_back(d);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic check_all();
        chk("uart_tx", uart_tx, exp_tx());
        chk("fifo_count", fifo_count, q.size());
        chk("tx_ready", tx_ready, q.size() != DEPTH);
        chk("busy", busy, (fpos >= 0) || (q.size() != 0));
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic decode();
        int k;
        if (!d_act) begin
            if (uart_tx == 1'b0) begin
                d_act = 1'b1;
                d_cnt = 0;
                prev_start = last_start;
                last_start = cyc;
            end
        end else begin
            d_cnt++;
            if (d_cnt >= DIV && d_cnt < 9 * DIV && d_cnt % DIV == DIV / 2) begin
                k = d_cnt / DIV - 1;
                d_byte[k] = uart_tx;
            end
            if (d_cnt == 9 * DIV + DIV / 2) begin
                chk("stop_bit", uart_tx, 1);
                if (sent.size() == 0) chk("rx_unexpected", sent.size(), 1);
                else chk("rx_byte", d_byte, sent.pop_front());
                d_act = 1'b0;
                n_frames++;
            end
        end
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit r);
        tx_valid = v;
        tx_data  = d;
        host_rts = r;
        @(posedge clk);
        model_update(v, d, r);
        @(negedge clk);
        cyc++;
        check_all();
        decode();
        tx_valid = 1'b0;
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, r);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_tx", uart_tx, 1);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        q.delete();
        sent.delete();
        fpos  = -1;
        m_ovf = 1'b0;
        d_act = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[7];
        int   base;
        int   g;

        vt[0] = '{1'b1, 8'h11, 1'b0, 1, 1, 1, 0};
        vt[1] = '{1'b1, 8'h22, 1'b0, 2, 1, 1, 0};
        vt[2] = '{1'b1, 8'h33, 1'b0, 3, 1, 1, 0};
        vt[3] = '{1'b1, 8'h44, 1'b0, 4, 0, 1, 0};
        vt[4] = '{1'b1, 8'h55, 1'b0, 4, 0, 1, 1};
        vt[5] = '{1'b0, 8'h00, 1'b0, 4, 0, 1, 1};
        vt[6] = '{1'b0, 8'h00, 1'b1, 3, 1, 0, 1};

        @(negedge clk);
        do_reset();

        // single frame, latency and busy length
        base = n_frames;
        step(1'b1, 8'h55, 1'b1);
        chk("t1_tx_e0", uart_tx, 1);
        step(1'b0, 8'h00, 1'b1);
        chk("t1_tx_e1", uart_tx, 0);
        idle(159, 1'b1);
        chk("t1_busy_end", busy, 1);
        step(1'b0, 8'h00, 1'b1);
        chk("t1_busy_done", busy, 0);
        chk("t1_frames", n_frames - base, 1);

        // three queued bytes, spacing 161
        base = n_frames;
        step(1'b1, 8'hA3, 1'b0);
        chk("t2_cnt1", fifo_count, 1);
        step(1'b1, 8'h00, 1'b0);
        chk("t2_cnt2", fifo_count, 2);
        step(1'b1, 8'hFF, 1'b0);
        chk("t2_cnt3", fifo_count, 3);
        step(1'b0, 8'h00, 1'b1);
        chk("t2_pop1", fifo_count, 2);
        idle(161, 1'b1);
        chk("t2_pop2", fifo_count, 1);
        chk("t2_space1", last_start - prev_start, 161);
        idle(161, 1'b1);
        chk("t2_pop3", fifo_count, 0);
        chk("t2_space2", last_start - prev_start, 161);
        idle(170, 1'b1);
        chk("t2_frames", n_frames - base, 3);

        // flow-controlled fill and overflow, table driven
        base = n_frames;
        foreach (vt[i]) begin
            step(vt[i].v, vt[i].d, vt[i].r);
            chk("t3_cnt", fifo_count, vt[i].e_cnt);
            chk("t3_rdy", tx_ready, vt[i].e_rdy);
            chk("t3_tx", uart_tx, vt[i].e_tx);
            chk("t3_ovf", overflow, vt[i].e_ovf);
        end
        idle(4 * 161 + 10, 1'b1);
        chk("t3_frames", n_frames - base, 4);
        chk("t3_empty", fifo_count, 0);

        // rts dropped during bit 3
        step(1'b1, 8'h5A, 1'b1);
        step(1'b1, 8'hC3, 1'b1);
        g = 0;
        while (fpos < 4 * DIV + 4 && g < 500) begin
            step(1'b0, 8'h00, 1'b1);
            g++;
        end
        g = 0;
        while (fpos >= 0 && g < 500) begin
            step(1'b0, 8'h00, 1'b0);
            g++;
        end
        chk("t4_bound", g < 500, 1);
        idle(50, 1'b0);
        chk("t4_held_cnt", fifo_count, 1);
        chk("t4_held_tx", uart_tx, 1);
        step(1'b0, 8'h00, 1'b1);
        chk("t4_resume", uart_tx, 0);
        idle(170, 1'b1);

        // reset during bit 5
        step(1'b1, 8'h00, 1'b1);
        step(1'b1, 8'h77, 1'b1);
        g = 0;
        while (fpos < 6 * DIV + 4 && g < 500) begin
            step(1'b0, 8'h00, 1'b1);
            g++;
        end
        chk("t5_tx_pre", uart_tx, 0);
        do_reset();
        base = n_frames;
        step(1'b1, 8'h3C, 1'b1);
        idle(170, 1'b1);
        chk("t5_frames", n_frames - base, 1);

        // push while full on the idle pop edge
        for (int i = 0; i < 5; i++) step(1'b1, 8'h81 + 8'(i), 1'b1);
        chk("t6_full", fifo_count, 4);
        g = 0;
        while (fpos >= 0 && g < 500) begin
            step(1'b0, 8'h00, 1'b1);
            g++;
        end
        step(1'b1, 8'hEE, 1'b1);
        chk("t6_cnt", fifo_count, 3);
        chk("t6_rdy", tx_ready, 1);
        chk("t6_ovf", overflow, 1);
        idle(4 * 161 + 10, 1'b1);

        // randomized traffic against the model
        do_reset();
        host_rts = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            bit r;
            r = host_rts;
            if ($urandom_range(0, 99) < 2) r = ~r;
            step($urandom_range(0, 5) == 0, 8'($urandom), r);
        end
        idle(5 * 161 + 20, 1'b1);
        chk("rnd_drained", sent.size(), 0);
        chk("rnd_empty", fifo_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
